// File: rtl/prefetcher_data_queue_pkg.sv
// prefetcher_pkg: shared opcode encoding, per-entry status flags and helpers for the
// prefetch data queue. The entry address and data payloads are held in separate
// arrays inside the queue so that their widths can follow the module parameters.
package prefetcher_pkg;

  typedef enum logic [2:0] {
    PR_NOP               = 3'd0,
    PR_READ_REQ_PREF     = 3'd1,
    PR_READ_REQ_MASTER   = 3'd2,
    PR_READ_DATA_SLAVE   = 3'd3,
    PR_READ_DATA_PROMISE = 3'd4
  } pr_opcode_t;

  typedef struct packed {
    logic has_data;
    logic promised;
    logic dropped;
    logic last;
  } pfq_entry_t;

  function automatic int unsigned block_data_size_bits(input int unsigned log_bytes);
    return 8 << log_bytes;
  endfunction

  function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [15:0] b);
    logic [16:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[16] ? 16'hFFFF : sum[15:0];
  endfunction

endpackage

// File: rtl/prefetcher_data_queue_cam.sv
// prefetcher_queue_cam: age-ordered address match. Scans entries starting at the head
// and reports the oldest candidate whose address equals the key, plus a mask of every
// slot between the head and that match (exclusive).
module prefetcher_queue_cam #(
  parameter int unsigned ADDR_BITS      = 64,
  parameter int unsigned LOG_QUEUE_SIZE = 6
) (
  input  logic [ADDR_BITS-1:0]            i_key,
  input  logic [ADDR_BITS-1:0]            i_addr [2**LOG_QUEUE_SIZE],
  input  logic [(2**LOG_QUEUE_SIZE)-1:0]  i_cand,
  input  logic [LOG_QUEUE_SIZE-1:0]       i_head,
  output logic                            o_hit,
  output logic [LOG_QUEUE_SIZE-1:0]       o_idx,
  output logic [(2**LOG_QUEUE_SIZE)-1:0]  o_older
);
  import prefetcher_pkg::*;

  localparam int unsigned N = 2**LOG_QUEUE_SIZE;

  logic [LOG_QUEUE_SIZE-1:0] w_slot;

  // Walk slots in age order; stop marking older slots at the first match.
  always_comb begin
    o_hit   = 1'b0;
    o_idx   = '0;
    o_older = '0;
    w_slot  = '0;
    for (int unsigned k = 0; k < N; k++) begin
      w_slot = i_head + LOG_QUEUE_SIZE'(k);
      if (!o_hit) begin
        if (i_cand[w_slot] && (i_addr[w_slot] == i_key)) begin
          o_hit = 1'b1;
          o_idx = w_slot;
        end else begin
          o_older[w_slot] = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/prefetcher_data_queue.sv
// prefetcher_data_queue: prefetch storage stage. Circular buffer of prefetch entries
// driven by the controller opcode stream (allocate, match, fill, pop).
// Optional statistics counters (hitCnt/missCnt/dropCnt) are built when PFQ_STATS_EN
// is defined.
module prefetcher_data_queue
  import prefetcher_pkg::*;
#(
  parameter int unsigned ADDR_BITS            = 64,
  parameter int unsigned LOG_QUEUE_SIZE       = 6,
  parameter int unsigned LOG_BLOCK_DATA_BYTES = 6,
  parameter int unsigned ALMOST_FULL_MARGIN   = 2,
  localparam int unsigned DW = block_data_size_bits(LOG_BLOCK_DATA_BYTES)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      dataFlushN,
  input  logic [2:0]                pr_opCode,
  input  logic [ADDR_BITS-1:0]      pr_addr,
  input  logic                      pr_r_out_last,
  input  logic [DW-1:0]             pr_r_out_data,
  output logic                      pr_addrHit,
  output logic                      pr_r_valid,
  output logic                      pr_r_in_last,
  output logic [DW-1:0]             pr_r_in_data,
  output logic                      pr_hasOutstanding,
  output logic [LOG_QUEUE_SIZE:0]   prefetchReqCnt,
  output logic                      almostFull
`ifdef PFQ_STATS_EN
  ,
  output logic [15:0]               hitCnt,
  output logic [15:0]               missCnt,
  output logic [15:0]               dropCnt
`endif
);

  localparam int unsigned N = 2**LOG_QUEUE_SIZE;
  localparam logic [LOG_QUEUE_SIZE:0] FULL_CNT = (LOG_QUEUE_SIZE+1)'(N);
  localparam logic [LOG_QUEUE_SIZE:0] AF_CNT   = (LOG_QUEUE_SIZE+1)'(N - ALMOST_FULL_MARGIN);

  logic [ADDR_BITS-1:0]      r_addr [N];
  logic [DW-1:0]             r_data [N];
  pfq_entry_t                r_ent  [N];
  logic [LOG_QUEUE_SIZE-1:0] r_head;
  logic [LOG_QUEUE_SIZE-1:0] r_tail;
  logic [LOG_QUEUE_SIZE:0]   r_cnt;
  logic                      r_addrHit;

  pr_opcode_t                w_op;
  logic [N-1:0]              w_cand;
  logic                      w_outstanding;
  logic [LOG_QUEUE_SIZE:0]   w_req_cnt;
  logic                      w_slv_found;
  logic [LOG_QUEUE_SIZE-1:0] w_slv_idx;
  logic [LOG_QUEUE_SIZE-1:0] w_slot;
  logic                      w_cam_hit;
  logic [LOG_QUEUE_SIZE-1:0] w_hit_idx;
  logic [N-1:0]              w_older;
  pfq_entry_t                w_head;
  logic                      w_nonempty;
  logic                      w_head_ready;
  logic                      w_drain;
  logic                      w_full;
  logic                      w_pop;
  logic                      w_alloc;
  logic                      w_is_hit;
  logic                      w_slv_write;
  logic [N-1:0]              w_drop_new;

  assign w_op = pr_opcode_t'(pr_opCode);

  // Age-ordered scan of live entries: match candidates, outstanding/fill target, req count.
  always_comb begin
    w_cand        = '0;
    w_outstanding = 1'b0;
    w_req_cnt     = '0;
    w_slv_found   = 1'b0;
    w_slv_idx     = '0;
    w_slot        = '0;
    for (int unsigned k = 0; k < N; k++) begin
      w_slot = r_head + LOG_QUEUE_SIZE'(k);
      if ((LOG_QUEUE_SIZE+1)'(k) < r_cnt) begin
        if (!r_ent[w_slot].has_data) begin
          w_outstanding = 1'b1;
          if (!w_slv_found) begin
            w_slv_found = 1'b1;
            w_slv_idx   = w_slot;
          end
        end
        if (!r_ent[w_slot].promised && !r_ent[w_slot].dropped) begin
          w_cand[w_slot] = 1'b1;
          w_req_cnt      = w_req_cnt + (LOG_QUEUE_SIZE+1)'(1);
        end
      end
    end
  end

  prefetcher_queue_cam #(
    .ADDR_BITS      (ADDR_BITS),
    .LOG_QUEUE_SIZE (LOG_QUEUE_SIZE)
  ) u_cam (
    .i_key   (pr_addr),
    .i_addr  (r_addr),
    .i_cand  (w_cand),
    .i_head  (r_head),
    .o_hit   (w_cam_hit),
    .o_idx   (w_hit_idx),
    .o_older (w_older)
  );

  assign w_head       = r_ent[r_head];
  assign w_nonempty   = (r_cnt != '0);
  assign w_head_ready = w_nonempty && w_head.has_data;
  assign w_drain      = w_head_ready && w_head.dropped;
  assign w_full       = (r_cnt == FULL_CNT);

  assign pr_addrHit        = r_addrHit;
  assign pr_r_valid        = w_head_ready && w_head.promised;
  assign pr_r_in_last      = w_head_ready ? w_head.last : 1'b0;
  assign pr_r_in_data      = w_head_ready ? r_data[r_head] : '0;
  assign pr_hasOutstanding = w_outstanding;
  assign prefetchReqCnt    = w_req_cnt;
  assign almostFull        = (r_cnt >= AF_CNT);

  // A dropped head and a promise pop are mutually exclusive, so at most one pop per edge.
  assign w_pop       = w_drain || ((w_op == PR_READ_DATA_PROMISE) && pr_r_valid);
  assign w_alloc     = (w_op == PR_READ_REQ_PREF) && !w_full;
  assign w_is_hit    = (w_op == PR_READ_REQ_MASTER) && w_cam_hit;
  assign w_slv_write = (w_op == PR_READ_DATA_SLAVE) && w_slv_found;
  // Older candidates are exactly the older live entries not yet promised or dropped.
  assign w_drop_new  = w_is_hit ? (w_older & w_cand) : '0;

  // Pointers, occupancy, entry flags and the registered hit pulse.
  always_ff @(posedge clk) begin
    if (reset || !dataFlushN) begin
      r_head    <= '0;
      r_tail    <= '0;
      r_cnt     <= '0;
      r_addrHit <= 1'b0;
      for (int unsigned i = 0; i < N; i++) begin
        r_ent[i] <= '0;
      end
    end else begin
      r_addrHit <= w_is_hit;
      for (int unsigned i = 0; i < N; i++) begin
        if (w_drop_new[i]) begin
          r_ent[i].dropped <= 1'b1;
        end
      end
      if (w_is_hit) begin
        r_ent[w_hit_idx].promised <= 1'b1;
      end
      if (w_slv_write) begin
        r_ent[w_slv_idx].has_data <= 1'b1;
        r_ent[w_slv_idx].last     <= pr_r_out_last;
      end
      if (w_alloc) begin
        r_ent[r_tail] <= '0;
        r_tail        <= r_tail + 1'b1;
      end
      if (w_pop) begin
        r_head <= r_head + 1'b1;
      end
      case ({w_alloc, w_pop})
        2'b10:   r_cnt <= r_cnt + (LOG_QUEUE_SIZE+1)'(1);
        2'b01:   r_cnt <= r_cnt - (LOG_QUEUE_SIZE+1)'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  // Address and data payloads; validity is governed entirely by the flags above.
  always_ff @(posedge clk) begin
    if (w_alloc) begin
      r_addr[r_tail] <= pr_addr;
    end
    if (w_slv_write) begin
      r_data[w_slv_idx] <= pr_r_out_data;
    end
  end

`ifdef PFQ_STATS_EN
  logic [15:0] r_hitCnt;
  logic [15:0] r_missCnt;
  logic [15:0] r_dropCnt;
  logic [15:0] w_drop_num;

  // Number of entries newly dropped by this cycle's hit.
  always_comb begin
    w_drop_num = '0;
    for (int unsigned i = 0; i < N; i++) begin
      w_drop_num = w_drop_num + {15'd0, w_drop_new[i]};
    end
  end

  // Saturating hit/miss/drop statistics, cleared with the queue.
  always_ff @(posedge clk) begin
    if (reset || !dataFlushN) begin
      r_hitCnt  <= '0;
      r_missCnt <= '0;
      r_dropCnt <= '0;
    end else begin
      if (w_is_hit) begin
        r_hitCnt <= sat_add16(r_hitCnt, 16'd1);
      end
      if ((w_op == PR_READ_REQ_MASTER) && !w_cam_hit) begin
        r_missCnt <= sat_add16(r_missCnt, 16'd1);
      end
      r_dropCnt <= sat_add16(r_dropCnt, w_drop_num);
    end
  end

  assign hitCnt  = r_hitCnt;
  assign missCnt = r_missCnt;
  assign dropCnt = r_dropCnt;
`endif

endmodule

// File: tb/tb_prefetcher_data_queue.sv
// Testbench for prefetcher_data_queue: directed vector table, hand-written corner
// sequences (fill/wrap, drop/auto-drain) and a randomized run against a queue-based
// reference model. Statistics outputs are checked when PFQ_STATS_EN is defined.
`timescale 1ns/1ps
module tb_prefetcher_data_queue;
  import prefetcher_pkg::*;

  localparam int unsigned AW     = 64;
  localparam int unsigned LQ     = 6;
  localparam int unsigned N      = 64;
  localparam int unsigned DW     = 512;
  localparam int unsigned MARGIN = 2;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            dataFlushN = 1'b1;
  logic [2:0]      pr_opCode = 3'd0;
  logic [AW-1:0]   pr_addr = '0;
  logic            pr_r_out_last = 1'b0;
  logic [DW-1:0]   pr_r_out_data = '0;
  logic            pr_addrHit;
  logic            pr_r_valid;
  logic            pr_r_in_last;
  logic [DW-1:0]   pr_r_in_data;
  logic            pr_hasOutstanding;
  logic [LQ:0]     prefetchReqCnt;
  logic            almostFull;
`ifdef PFQ_STATS_EN
  logic [15:0]     hitCnt;
  logic [15:0]     missCnt;
  logic [15:0]     dropCnt;
`endif

  prefetcher_data_queue #(
    .ADDR_BITS            (AW),
    .LOG_QUEUE_SIZE       (LQ),
    .LOG_BLOCK_DATA_BYTES (6),
    .ALMOST_FULL_MARGIN   (MARGIN)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .dataFlushN        (dataFlushN),
    .pr_opCode         (pr_opCode),
    .pr_addr           (pr_addr),
    .pr_r_out_last     (pr_r_out_last),
    .pr_r_out_data     (pr_r_out_data),
    .pr_addrHit        (pr_addrHit),
    .pr_r_valid        (pr_r_valid),
    .pr_r_in_last      (pr_r_in_last),
    .pr_r_in_data      (pr_r_in_data),
    .pr_hasOutstanding (pr_hasOutstanding),
    .prefetchReqCnt    (prefetchReqCnt),
    .almostFull        (almostFull)
`ifdef PFQ_STATS_EN
    ,
    .hitCnt            (hitCnt),
    .missCnt           (missCnt),
    .dropCnt           (dropCnt)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] beat(input int i);
    logic [DW-1:0] d;
    for (int w = 0; w < 16; w++) d[w*32 +: 32] = 32'hA500_0000 + 32'(i) + 32'(w << 16);
    return d;
  endfunction

  function automatic logic [DW-1:0] rnd_data();
    logic [DW-1:0] d;
    for (int w = 0; w < 16; w++) d[w*32 +: 32] = $urandom();
    return d;
  endfunction

  // ---------------- reference model: queue of entries, oldest first ----------------
  typedef struct {
    logic [AW-1:0] addr;
    bit            has_data;
    bit            promised;
    bit            dropped;
    bit            last;
    logic [DW-1:0] data;
  } m_ent_t;

  m_ent_t mq[$];
  bit     m_hit = 1'b0;

  task automatic model_step(input bit rst, input bit fl_n, input int op,
                            input logic [AW-1:0] a, input bit lst, input logic [DW-1:0] d);
    bit     full;
    bit     pop;
    m_ent_t e;
    if (rst || !fl_n) begin
      mq.delete();
      m_hit = 1'b0;
      return;
    end
    full  = (mq.size() == N);
    pop   = 1'b0;
    m_hit = 1'b0;
    if (mq.size() > 0 && mq[0].has_data && (mq[0].dropped || (op == 4 && mq[0].promised)))
      pop = 1'b1;
    if (op == 2) begin
      for (int i = 0; i < mq.size(); i++) begin
        if (!mq[i].promised && !mq[i].dropped && mq[i].addr == a) begin
          m_hit = 1'b1;
          e = mq[i]; e.promised = 1'b1; mq[i] = e;
          for (int j = 0; j < i; j++) begin
            if (!mq[j].promised) begin e = mq[j]; e.dropped = 1'b1; mq[j] = e; end
          end
          break;
        end
      end
    end
    if (op == 3) begin
      for (int i = 0; i < mq.size(); i++) begin
        if (!mq[i].has_data) begin
          e = mq[i]; e.has_data = 1'b1; e.last = lst; e.data = d; mq[i] = e;
          break;
        end
      end
    end
    if (pop) void'(mq.pop_front());
    if (op == 1 && !full) begin
      e.addr = a; e.has_data = 0; e.promised = 0; e.dropped = 0; e.last = 0; e.data = '0;
      mq.push_back(e);
    end
  endtask

  task automatic check_model();
    bit v;
    bit ho;
    int rc;
    v  = (mq.size() > 0) && mq[0].promised && mq[0].has_data;
    ho = 1'b0;
    rc = 0;
    foreach (mq[i]) begin
      if (!mq[i].has_data) ho = 1'b1;
      if (!mq[i].promised && !mq[i].dropped) rc++;
    end
    chk("m_addrHit", pr_addrHit, m_hit);
    chk("m_r_valid", pr_r_valid, v);
    if (v) begin
      chk("m_r_last", pr_r_in_last, mq[0].last);
      chk("m_r_data", pr_r_in_data, mq[0].data);
    end
    chk("m_hasOutstanding", pr_hasOutstanding, ho);
    chk("m_prefetchReqCnt", prefetchReqCnt, DW'(rc));
    chk("m_almostFull", almostFull, (mq.size() >= N - MARGIN));
  endtask

  // Drive one opcode cycle, advance the model with the same inputs, sample after the edge.
  task automatic step(input bit rst, input bit fl_n, input int op,
                      input logic [AW-1:0] a, input bit lst, input logic [DW-1:0] d);
    reset         = rst;
    dataFlushN    = fl_n;
    pr_opCode     = 3'(op);
    pr_addr       = a;
    pr_r_out_last = lst;
    pr_r_out_data = d;
    @(posedge clk);
    model_step(rst, fl_n, op, a, lst, d);
    #1;
    reset      = 1'b0;
    dataFlushN = 1'b1;
    pr_opCode  = 3'd0;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    bit            fl_n;
    int            op;
    logic [AW-1:0] addr;
    bit            lst;
    int            bidx;
    bit            e_hit;
    bit            e_valid;
    int            e_req;
    bit            e_out;
    int            e_data;
    bit            e_last;
  } vec_t;

  vec_t vt[$];

  initial begin
    vec_t v;
    string nm;

    // reset state
    step(1, 1, 0, '0, 0, '0);
    chk("rst_addrHit", pr_addrHit, 0);
    chk("rst_r_valid", pr_r_valid, 0);
    chk("rst_r_last", pr_r_in_last, 0);
    chk("rst_r_data", pr_r_in_data, '0);
    chk("rst_hasOutstanding", pr_hasOutstanding, 0);
    chk("rst_reqCnt", prefetchReqCnt, 0);
    chk("rst_almostFull", almostFull, 0);

    //               fl op addr        lst b   hit vld req out data last
    vt.push_back('{1, 1, 64'h100, 0, 0,  0, 0, 1, 1, -1, 0});
    vt.push_back('{1, 1, 64'h140, 0, 0,  0, 0, 2, 1, -1, 0});
    vt.push_back('{1, 1, 64'h180, 0, 0,  0, 0, 3, 1, -1, 0});
    vt.push_back('{1, 3, 64'h0,   0, 0,  0, 0, 3, 1, -1, 0});
    vt.push_back('{1, 3, 64'h0,   0, 1,  0, 0, 3, 1, -1, 0});
    vt.push_back('{1, 3, 64'h0,   1, 2,  0, 0, 3, 0, -1, 0});
    vt.push_back('{1, 2, 64'h100, 0, 0,  1, 1, 2, 0,  0, 0});
    vt.push_back('{1, 0, 64'h0,   0, 0,  0, 1, 2, 0,  0, 0});
    vt.push_back('{1, 4, 64'h0,   0, 0,  0, 0, 2, 0, -1, 0});
    vt.push_back('{1, 2, 64'h700, 0, 0,  0, 0, 2, 0, -1, 0});
    vt.push_back('{1, 2, 64'h180, 0, 0,  1, 0, 0, 0, -1, 0});
    vt.push_back('{1, 0, 64'h0,   0, 0,  0, 1, 0, 0,  2, 1});
    vt.push_back('{1, 4, 64'h0,   0, 0,  0, 0, 0, 0, -1, 0});
    vt.push_back('{1, 1, 64'h200, 0, 0,  0, 0, 1, 1, -1, 0});
    vt.push_back('{1, 1, 64'h240, 0, 0,  0, 0, 2, 1, -1, 0});
    vt.push_back('{1, 1, 64'h280, 0, 0,  0, 0, 3, 1, -1, 0});
    vt.push_back('{1, 2, 64'h280, 0, 0,  1, 0, 0, 1, -1, 0});
    vt.push_back('{1, 3, 64'h0,   0, 10, 0, 0, 0, 1, -1, 0});
    vt.push_back('{1, 3, 64'h0,   0, 11, 0, 0, 0, 1, -1, 0});
    vt.push_back('{1, 3, 64'h0,   1, 12, 0, 1, 0, 0, 12, 1});
    vt.push_back('{1, 0, 64'h0,   0, 0,  0, 1, 0, 0, 12, 1});
    vt.push_back('{0, 1, 64'h300, 0, 0,  0, 0, 0, 0, -1, 0});

    for (int i = 0; i < vt.size(); i++) begin
      v = vt[i];
      step(0, v.fl_n, v.op, v.addr, v.lst, beat(v.bidx));
      nm = $sformatf("vec%0d", i);
      chk({nm, "_addrHit"}, pr_addrHit, v.e_hit);
      chk({nm, "_r_valid"}, pr_r_valid, v.e_valid);
      chk({nm, "_reqCnt"}, prefetchReqCnt, DW'(v.e_req));
      chk({nm, "_hasOutstanding"}, pr_hasOutstanding, v.e_out);
      if (v.e_data >= 0) begin
        chk({nm, "_r_data"}, pr_r_in_data, beat(v.e_data));
        chk({nm, "_r_last"}, pr_r_in_last, v.e_last);
      end
    end

    // fill to capacity, ignored alloc when full, then pointer wrap
    step(1, 1, 0, '0, 0, '0);
    for (int i = 0; i < int'(N); i++) begin
      step(0, 1, 1, 64'h1000 + 64'(i * 'h40), 0, '0);
      if (i == int'(N - MARGIN) - 2) chk("fill_af_below", almostFull, 0);
      if (i == int'(N - MARGIN) - 1) chk("fill_af_at", almostFull, 1);
    end
    chk("full_reqCnt", prefetchReqCnt, DW'(N));
    step(0, 1, 1, 64'h999, 0, '0);
    chk("full_ignored_reqCnt", prefetchReqCnt, DW'(N));
    chk("full_almostFull", almostFull, 1);
    step(0, 1, 2, 64'h999, 0, '0);
    chk("full_ignored_miss", pr_addrHit, 0);
    step(0, 1, 2, 64'h1000, 0, '0);
    chk("full_hit_head", pr_addrHit, 1);
    step(0, 1, 3, '0, 0, beat(20));
    chk("full_head_valid", pr_r_valid, 1);
    chk("full_head_data", pr_r_in_data, beat(20));
    step(0, 1, 4, '0, 0, '0);
    chk("pop_head_valid", pr_r_valid, 0);
    step(0, 1, 1, 64'h999, 0, '0);
    chk("wrap_alloc_reqCnt", prefetchReqCnt, DW'(N));
    step(0, 1, 2, 64'h999, 0, '0);
    chk("wrap_hit", pr_addrHit, 1);
    chk("wrap_drop_reqCnt", prefetchReqCnt, 0);
    for (int i = 0; i < int'(N); i++) begin
      step(0, 1, 3, '0, (i == int'(N) - 1), beat(30 + i));
      check_model();
    end
    chk("wrap_valid", pr_r_valid, 1);
    chk("wrap_data", pr_r_in_data, beat(30 + int'(N) - 1));
    chk("wrap_last", pr_r_in_last, 1);
    chk("wrap_hasOutstanding", pr_hasOutstanding, 0);

`ifdef PFQ_STATS_EN
    step(1, 1, 0, '0, 0, '0);
    step(0, 1, 1, 64'h400, 0, '0);
    step(0, 1, 1, 64'h440, 0, '0);
    step(0, 1, 1, 64'h480, 0, '0);
    step(0, 1, 2, 64'h480, 0, '0);
    step(0, 1, 2, 64'h777, 0, '0);
    chk("stats_hitCnt", hitCnt, 1);
    chk("stats_missCnt", missCnt, 1);
    chk("stats_dropCnt", dropCnt, 2);
    step(0, 0, 0, '0, 0, '0);
    chk("stats_flush_hit", hitCnt, 0);
    chk("stats_flush_miss", missCnt, 0);
    chk("stats_flush_drop", dropCnt, 0);
`endif

    // randomized run against the reference model
    step(1, 1, 0, '0, 0, '0);
    for (int c = 0; c < 3000; c++) begin
      int r;
      int op;
      r  = int'($urandom_range(0, 99));
      op = (r < 25) ? 1 : (r < 45) ? 2 : (r < 70) ? 3 : (r < 90) ? 4 : 0;
      step(0, ($urandom_range(0, 199) != 0), op, 64'h100 * 64'($urandom_range(0, 15)),
           1'($urandom_range(0, 1)), rnd_data());
      check_model();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
